serial_add_sub: RTL
===================

Name: serial_add_sub

Overview:
Parametrised multi-cycle adder/subtractor. It is the sequential successor to the combinational half/full adder cells. It processes WIDTH-bit operands DIGIT bits per clock through one DIGIT-wide ripple stage, and keeps the carry in a register between steps. A start/busy/done handshake lets a controller or testbench issue one operation at a time. Signed-overflow and carry-out flags are reported with the result.

Parameters:
WIDTH, 8, operand and result width in bits; must be >= 2.
DIGIT, 1, bits processed per clock; WIDTH % DIGIT == 0 required (elaboration error otherwise).
STEPS, WIDTH/DIGIT, derived local parameter: number of RUN cycles.

Ports:
clk    input   1      rising-edge clock
rst    input   1      asynchronous, active-high reset
start  input   1      request; sampled only when busy=0
sub    input   1      0: a+b+cin; 1: a-b (a + ~b + 1), cin ignored
a      input   WIDTH  operand A, sampled with start
b      input   WIDTH  operand B, sampled with start
cin    input   1      carry-in for add mode, sampled with start
busy   output  1      high while operation in progress
done   output  1      one-cycle pulse; result valid
sum    output  WIDTH  result, registered
cout   output  1      carry out of MSB (sub mode: 1 = no borrow)
ovf    output  1      two's-complement overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Reset (asynchronous, any time): state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0; internal shift registers, carry and step counter cleared. An operation in flight is aborted with no done pulse.
- States are IDLE, RUN and DONE.
- IDLE: if start=1 at an edge, do the following and go to RUN, busy=1:
  - latch a into shift register A;
  - latch (sub ? ~b : b) into shift register B;
  - set the carry register to (sub ? 1 : cin);
  - set the step counter to 0.
- RUN: each edge adds the low DIGIT bits of A and B plus the carry. The DIGIT-bit result is shifted into the top of the result shift register. The carry register takes the stage carry-out. A and B shift right by DIGIT and the counter increments. The carry into the MSB is recorded on the final step. On the edge completing step STEPS-1 the block does all of the following:
  - go to DONE;
  - load sum from the result shift register;
  - set cout = final carry and ovf = carry-into-MSB ^ final carry;
  - busy=0, done=1.
- DONE: lasts exactly one cycle (done=1, busy=0). The next edge clears done and moves to IDLE. start=1 at that edge is accepted exactly as in IDLE (back-to-back operation; no dead cycle).
- Latency: start sampled at edge E0 -> done high in the cycle after edge E0+STEPS. Throughput is one operation per STEPS+1 cycles.
- sum, cout and ovf change only on the completion edge or on reset. They hold their value through IDLE, DONE and the following RUN until the next completion.
- start while busy=1 is ignored. Input changes on a, b, sub and cin during RUN have no effect.
- Arithmetic is modulo 2^WIDTH. In sub mode, cout=1 means a>=b unsigned.
- DIGIT=WIDTH is legal: STEPS=1, done one cycle after the start edge.

Test Plan:
1. WIDTH=8, DIGIT=1, add: a=0x0F, b=0x01, cin=0 -> done pulse 8 edges after the start edge; sum=0x10, cout=0, ovf=0; busy high for exactly 8 cycles.
2. Add wrap and overflow: 0xFF+0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Then 0x7F+0x01 -> sum=0x80, cout=0, ovf=1. 0x7F+0x00 with cin=1 -> sum=0x80, ovf=1.
3. Subtract: sub=1, 0x05-0x07 -> sum=0xFE, cout=0, ovf=0. Then 0x80-0x01 -> sum=0x7F, cout=1, ovf=1. cin=1 must not alter either result.
4. Handshake: pulse start again mid-RUN with different operands -> ignored; first result is unchanged. Assert start during the DONE cycle -> second operation starts immediately, busy=1 next cycle, correct second result.
5. Reset mid-operation: assert rst asynchronously between edges at step 3 -> busy, done, sum, cout and ovf go to 0 immediately; no done pulse. A new start after release gives a correct result.
6. Re-parametrise WIDTH=16, DIGIT=4: 0xFFFF+0x0001 -> done 4 edges after start, sum=0x0000, cout=1. Also run an exhaustive random compare against a behavioural a±b model for 1000 operations.

Source files
------------

// File: rtl/serial_add_sub_if.sv
// Handshake and operand/result bundle for the serial adder/subtractor.
// The controller side uses the master modport, the arithmetic block the slave.
interface serial_add_sub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_add_sub.sv
// Multi-cycle adder/subtractor: one DIGIT-wide ripple stage is reused for
// WIDTH/DIGIT steps, with the carry held in a register between steps.
//
// state | meaning
// IDLE  | waiting for start; result outputs hold the last completed result
// RUN   | one DIGIT slice added per clock, LSB slice first
// DONE  | single-cycle done pulse; start is accepted here as in IDLE
module serial_add_sub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic            clk,
  input logic            rst,
  serial_add_sub_if.slave bus
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  if (WIDTH < 2) begin : g_bad_width
    $error("serial_add_sub: WIDTH must be at least 2");
  end
  if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("serial_add_sub: DIGIT must divide WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [DIGIT:0]   stage;
  logic [DIGIT-1:0] stage_s;
  logic             stage_c;
  logic             c_into_msb;
  logic [WIDTH-1:0] res_next;
  logic             last_step;

  // One ripple stage over the low DIGIT bits of the operand shifters.
  always_comb begin
    stage      = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]}
                 + {{DIGIT{1'b0}}, carry};
    stage_s    = stage[DIGIT-1:0];
    stage_c    = stage[DIGIT];
    // On the final step the top stage bit is the operand MSB; its carry-in
    // falls out of the sum bit and the two operand bits.
    c_into_msb = a_sh[DIGIT-1] ^ b_sh[DIGIT-1] ^ stage_s[DIGIT-1];
    last_step  = (cnt == LAST);
  end

  // The result shifter only needs to remember the WIDTH-DIGIT bits already
  // produced; the current slice completes the word.
  if (STEPS == 1) begin : g_single
    always_comb res_next = stage_s;
  end else begin : g_multi
    logic [WIDTH-DIGIT-1:0] res_sh;

    always_comb res_next = {stage_s, res_sh};

    // New slices enter at the top so the first (LSB) slice ends at bit 0.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        res_sh <= '0;
      else if (state == RUN)
        res_sh <= res_next[WIDTH-1:DIGIT];
    end
  end

  // Sequencer, operand shifters, carry, step counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.sum  <= '0;
      bus.cout <= 1'b0;
      bus.ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            a_sh     <= bus.a;
            b_sh     <= bus.sub ? ~bus.b : bus.b;
            carry    <= bus.sub ? 1'b1 : bus.cin;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end else begin
            state    <= IDLE;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> DIGIT;
          b_sh  <= b_sh >> DIGIT;
          carry <= stage_c;
          cnt   <= cnt + CW'(1);
          if (last_step) begin
            bus.sum  <= res_next;
            bus.cout <= stage_c;
            bus.ovf  <= c_into_msb ^ stage_c;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            state    <= DONE;
          end
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
        end
      endcase
    end
  end

endmodule
